// File: rtl/kudu_dv_pkg.sv
// Shared types for the data-memory port arbiter (data_bus_arbiter).
package kudu_dv_pkg;

   // Number of requesters sharing the downstream data port
   localparam int unsigned DBA_NREQ = 2;

   // Requester ID: 0 = core LSU (m0), 1 = secondary bus master (m1)
   typedef logic dba_id_t;

   // IDLE: nothing pending downstream; LOCKED: selected request is
   // presented on s_* and waits for s_gnt
   typedef enum logic {
      DBA_IDLE   = 1'b0,
      DBA_LOCKED = 1'b1
   } dba_state_e;

endpackage

// File: rtl/data_bus_arbiter_if.sv
// OBI-style data port bundle: request phase plus in-order response phase.
// Used by data_bus_arbiter for both upstream requesters and the downstream port.
interface data_bus_arbiter_if #(
   parameter int unsigned DW = 65
) ();

   logic          req;
   logic          we;
   logic [3:0]    be;
   logic          is_cap;
   logic [31:0]   addr;
   logic [DW-1:0] wdata;
   logic [7:0]    flag;
   logic          gnt;
   logic          rvalid;
   logic [DW-1:0] rdata;
   logic          err;

   // Side issuing requests and receiving responses
   modport master (
      output req, we, be, is_cap, addr, wdata, flag,
      input  gnt, rvalid, rdata, err
   );

   // Side accepting requests and returning responses
   modport slave (
      input  req, we, be, is_cap, addr, wdata, flag,
      output gnt, rvalid, rdata, err
   );

endinterface

// File: rtl/dba_id_fifo.sv
// In-order FIFO of requester IDs for granted-but-unanswered transactions.
// DEPTH must be a power of two so the pointers wrap naturally.
module dba_id_fifo
   import kudu_dv_pkg::*;
#(
   parameter  int unsigned DEPTH = 4,
   localparam int unsigned AW    = $clog2(DEPTH),
   localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          push_i,
   input  logic          pop_i,
   input  dba_id_t       din_i,
   output dba_id_t       dout_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);

   dba_id_t       mem_q [DEPTH];
   logic [AW-1:0] wptr_q, wptr_d;
   logic [AW-1:0] rptr_q, rptr_d;
   logic [CW-1:0] count_q, count_d;

   // Pointer and occupancy update; push and pop together leave the count alone
   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage and pointer registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '{default: '0};
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (push_i) mem_q[wptr_q] <= din_i;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign dout_o  = mem_q[rptr_q];
   assign count_o = count_q;
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-requester arbiter for the data-memory port with in-order response steering.
// Build option: define DBA_RR_EN for round-robin contention handling; without it
// m0 always wins contention.
module data_bus_arbiter
   import kudu_dv_pkg::*;
#(
   parameter  int unsigned DW        = 65,
   parameter  int unsigned MAX_OUTST = 4,
   localparam int unsigned CW        = $clog2(MAX_OUTST) + 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   data_bus_arbiter_if.slave     m0,
   data_bus_arbiter_if.slave     m1,
   data_bus_arbiter_if.master    s,
   output logic [CW-1:0]         outst_cnt_o,
   output logic                  proto_err_o
);

   dba_state_e          state_q, state_d;
   dba_id_t             sel_q, sel_d;
   dba_id_t             win;
   dba_id_t             sel;
   logic                sel_vld;
   logic                req_out;
   logic                hs;
   logic [DBA_NREQ-1:0] req_vec;
   logic                fifo_full;
   logic                fifo_empty;
   dba_id_t             head_id;
   logic                rsp_vld;
   logic                proto_err_q, proto_err_d;
   logic [DW-1:0]       sel_wdata;

   assign req_vec = {m1.req, m0.req};

`ifdef DBA_RR_EN
   dba_id_t last_q, last_d;

   // Contention goes to the requester that was not granted last
   always_comb begin
      if (req_vec == 2'b11) win = ~last_q;
      else                  win = (req_vec == 2'b10);
   end

   // Last-granted pointer follows every downstream handshake
   always_comb begin
      last_d = hs ? sel : last_q;
   end

   // Pointer register; resets to m1 so m0 is favoured first
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) last_q <= 1'b1;
      else        last_q <= last_d;
   end
`else
   // Fixed priority: m1 wins only when m0 is not requesting
   always_comb begin
      win = m1.req & ~m0.req;
   end
`endif

   // Selection and lock tracking: a locked selection holds until granted
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      sel     = win;
      sel_vld = 1'b0;
      case (state_q)
         DBA_LOCKED: begin
            sel     = sel_q;
            sel_vld = req_vec[sel_q];
         end
         default: begin
            sel     = win;
            sel_vld = |req_vec;
         end
      endcase
      req_out = sel_vld & ~fifo_full;
      hs      = req_out & s.gnt;
      if (hs) begin
         state_d = DBA_IDLE;
      end else if (sel_vld) begin
         state_d = DBA_LOCKED;
         sel_d   = sel;
      end else begin
         state_d = DBA_IDLE;
      end
   end

   // Arbitration state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= DBA_IDLE;
         sel_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   // Downstream request mux and upstream grants; fields are zero with no selection
   always_comb begin
      sel_wdata = '0;
      s.req     = 1'b0;
      s.we      = 1'b0;
      s.be      = '0;
      s.is_cap  = 1'b0;
      s.addr    = '0;
      s.flag    = '0;
      if (sel_vld) begin
         s.req = req_out;
         if (sel) begin
            s.we      = m1.we;
            s.be      = m1.be;
            s.is_cap  = m1.is_cap;
            s.addr    = m1.addr;
            sel_wdata = m1.wdata;
            s.flag    = m1.flag;
         end else begin
            s.we      = m0.we;
            s.be      = m0.be;
            s.is_cap  = m0.is_cap;
            s.addr    = m0.addr;
            sel_wdata = m0.wdata;
            s.flag    = m0.flag;
         end
      end
      s.wdata = sel_wdata;
      m0.gnt  = hs & (sel == 1'b0);
      m1.gnt  = hs & (sel == 1'b1);
   end

   // Response steering by the oldest outstanding ID
   always_comb begin
      rsp_vld   = s.rvalid & ~fifo_empty;
      m0.rvalid = rsp_vld & (head_id == 1'b0);
      m1.rvalid = rsp_vld & (head_id == 1'b1);
      m0.rdata  = m0.rvalid ? s.rdata : '0;
      m1.rdata  = m1.rvalid ? s.rdata : '0;
      m0.err    = m0.rvalid & s.err;
      m1.err    = m1.rvalid & s.err;
   end

   // Responses with nothing outstanding latch a sticky protocol error
   always_comb begin
      proto_err_d = proto_err_q | (s.rvalid & fifo_empty);
   end

   // Protocol error register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) proto_err_q <= 1'b0;
      else        proto_err_q <= proto_err_d;
   end

   assign proto_err_o = proto_err_q;

   dba_id_fifo #(
      .DEPTH (MAX_OUTST)
   ) u_id_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (hs),
      .pop_i   (rsp_vld),
      .din_i   (sel),
      .dout_o  (head_id),
      .count_o (outst_cnt_o),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Randomized scoreboard bench for data_bus_arbiter (DW=65, MAX_OUTST=4).
// Honours DBA_RR_EN the same way as the design build.
module tb_data_bus_arbiter;

   localparam int unsigned DW        = 65;
   localparam int unsigned MAX_OUTST = 4;
   localparam int unsigned CW        = $clog2(MAX_OUTST) + 1;
`ifdef DBA_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CW-1:0] outst_cnt;
   logic          proto_err;

   always #5 clk = ~clk;

   data_bus_arbiter_if #(.DW(DW)) m0_if ();
   data_bus_arbiter_if #(.DW(DW)) m1_if ();
   data_bus_arbiter_if #(.DW(DW)) s_if ();

   data_bus_arbiter #(.DW(DW), .MAX_OUTST(MAX_OUTST)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .m0          (m0_if),
      .m1          (m1_if),
      .s           (s_if),
      .outst_cnt_o (outst_cnt),
      .proto_err_o (proto_err)
   );

   typedef struct packed {
      logic          we;
      logic [3:0]    be;
      logic          is_cap;
      logic [31:0]   addr;
      logic [DW-1:0] wdata;
      logic [7:0]    flag;
   } txn_t;

   typedef struct {
      int            id;
      logic [DW-1:0] rdata;
      logic          err;
   } rsp_t;

   typedef struct {
      logic          sreq;
      logic [31:0]   addr;
      logic [DW-1:0] wdata;
      logic [13:0]   ctl;
      int            cnt;
      logic          perr;
      logic          rv;
   } st_t;

   int   gnt_q[$];
   rsp_t rsp_q[$];
   st_t  st_q[$];

   // reference model: who owns the address phase, who is outstanding, in order
   txn_t mt[2];
   bit   mreq[2];
   bit   lock_v;
   int   lock_id;
   int   rr_last;
   int   outst[$];
   bit   perr_m;

   int   req_pct, gnt_pct, rv_pct;
   bit   spurious, in_reset;
   int   tests = 0, fails = 0;

   task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      t.we     = 1'($urandom);
      t.be     = 4'($urandom);
      t.is_cap = 1'($urandom);
      t.addr   = $urandom;
      t.wdata  = {$urandom, $urandom, 1'($urandom)};
      t.flag   = 8'($urandom);
      return t;
   endfunction

   task automatic apply();
      m0_if.req = mreq[0];
      m1_if.req = mreq[1];
      {m0_if.we, m0_if.be, m0_if.is_cap, m0_if.addr, m0_if.wdata, m0_if.flag} = mt[0];
      {m1_if.we, m1_if.be, m1_if.is_cap, m1_if.addr, m1_if.wdata, m1_if.flag} = mt[1];
   endtask

   // One clock of stimulus plus the model's prediction for that clock
   task automatic cycle();
      int   owner;
      bit   full, sreq, hs;
      st_t  st;
      rsp_t r;
      @(posedge clk);
      #1;
      rst_n = !in_reset;
      if (in_reset) begin
         mreq[0] = 0; mreq[1] = 0;
         lock_v = 0; rr_last = 1; outst.delete(); perr_m = 0;
         s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.err = 0;
         apply();
         #1;
         st = '{sreq: 0, addr: '0, wdata: '0, ctl: '0, cnt: 0, perr: 0, rv: 0};
         st_q.push_back(st);
         return;
      end
      for (int m = 0; m < 2; m++)
         if (!mreq[m] && $urandom_range(99) < req_pct) begin
            mt[m] = rand_txn();
            mreq[m] = 1;
         end else if (!mreq[m]) begin
            mt[m] = rand_txn();
         end
      s_if.gnt    = ($urandom_range(99) < gnt_pct);
      s_if.rvalid = spurious || (outst.size() > 0 && $urandom_range(99) < rv_pct);
      s_if.rdata  = {$urandom, $urandom, 1'($urandom)};
      s_if.err    = 1'($urandom);
      apply();
      #1;
      owner = -1;
      if (lock_v)                 owner = lock_id;
      else if (mreq[0] && mreq[1]) owner = RR ? 1 - rr_last : 0;
      else if (mreq[0])           owner = 0;
      else if (mreq[1])           owner = 1;
      full = (outst.size() == MAX_OUTST);
      sreq = (owner >= 0) && !full;
      hs   = sreq && s_if.gnt;
      st.sreq  = sreq;
      st.addr  = (owner >= 0) ? mt[owner].addr : '0;
      st.wdata = (owner >= 0) ? mt[owner].wdata : '0;
      st.ctl   = (owner >= 0) ? {mt[owner].we, mt[owner].be, mt[owner].is_cap, mt[owner].flag} : '0;
      st.cnt   = outst.size();
      st.perr  = perr_m;
      st.rv    = s_if.rvalid && (outst.size() > 0);
      st_q.push_back(st);
      if (s_if.rvalid) begin
         if (outst.size() > 0) begin
            r.id    = outst.pop_front();
            r.rdata = s_if.rdata;
            r.err   = s_if.err;
            rsp_q.push_back(r);
         end else begin
            perr_m = 1;
         end
      end
      if (hs) begin
         gnt_q.push_back(owner);
         outst.push_back(owner);
         rr_last = owner;
         lock_v = 0;
         mreq[owner] = 0;
      end else if (owner >= 0) begin
         lock_v = 1;
         lock_id = owner;
      end
   endtask

   // Monitor: compares whatever the DUT presents against the queued expectations
   always @(negedge clk) begin
      st_t  e;
      rsp_t r;
      int   gid, rid;
      if (st_q.size() > 0) begin
         e = st_q.pop_front();
         chk("s_req", 128'(s_if.req), 128'(e.sreq));
         chk("s_addr", 128'(s_if.addr), 128'(e.addr));
         chk("s_wdata", 128'(s_if.wdata), 128'(e.wdata));
         chk("s_ctl", 128'({s_if.we, s_if.be, s_if.is_cap, s_if.flag}), 128'(e.ctl));
         chk("outst_cnt", 128'(outst_cnt), 128'(e.cnt));
         chk("proto_err", 128'(proto_err), 128'(e.perr));
         chk("any_rvalid", 128'(m0_if.rvalid | m1_if.rvalid), 128'(e.rv));
      end
      if (m0_if.gnt || m1_if.gnt) begin
         gid = m1_if.gnt ? 1 : 0;
         chk("gnt_both", 128'(m0_if.gnt & m1_if.gnt), 128'(0));
         if (gnt_q.size() == 0) chk("gnt_unexpected", 128'(1), 128'(0));
         else chk("gnt_id", 128'(gid), 128'(gnt_q.pop_front()));
      end
      if (m0_if.rvalid || m1_if.rvalid) begin
         rid = m1_if.rvalid ? 1 : 0;
         chk("rsp_both", 128'(m0_if.rvalid & m1_if.rvalid), 128'(0));
         if (rsp_q.size() == 0) chk("rsp_unexpected", 128'(1), 128'(0));
         else begin
            r = rsp_q.pop_front();
            chk("rsp_id", 128'(rid), 128'(r.id));
            chk("rsp_rdata", 128'(rid ? m1_if.rdata : m0_if.rdata), 128'(r.rdata));
            chk("rsp_err", 128'(rid ? m1_if.err : m0_if.err), 128'(r.err));
            chk("rsp_other", 128'({rid ? m0_if.rdata : m1_if.rdata, rid ? m0_if.err : m1_if.err}), 128'(0));
         end
      end
   end

   task automatic phase(int rq, int gn, int rv, int n);
      req_pct = rq; gnt_pct = gn; rv_pct = rv;
      repeat (n) cycle();
   endtask

   task automatic drain();
      int i;
      req_pct = 0; gnt_pct = 100; rv_pct = 100;
      for (i = 0; i < 200 && (outst.size() > 0 || mreq[0] || mreq[1]); i++) cycle();
      if (outst.size() > 0 || mreq[0] || mreq[1]) chk("drain_timeout", 128'(1), 128'(0));
   endtask

   task automatic do_reset(int n);
      in_reset = 1;
      repeat (n) cycle();
      in_reset = 0;
   endtask

   initial begin
      rst_n = 0; in_reset = 1; spurious = 0;
      mreq[0] = 0; mreq[1] = 0; mt[0] = '0; mt[1] = '0;
      lock_v = 0; lock_id = 0; rr_last = 1; perr_m = 0;
      s_if.gnt = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.err = 0;
      apply();
      repeat (3) cycle();
      in_reset = 0;
      phase(50, 60, 50, 300);   // mixed traffic
      phase(80, 80, 0, 30);     // no responses: FIFO fills, s_req held low
      phase(50, 50, 100, 40);   // drain with traffic
      phase(100, 100, 100, 60); // contention with back-to-back grants
      phase(60, 10, 40, 150);   // long address-phase locks
      drain();
      spurious = 1; cycle(); spurious = 0;
      phase(0, 0, 0, 5);        // proto_err must stay set
      do_reset(2);
      phase(0, 0, 0, 3);        // proto_err cleared
      phase(100, 100, 0, 10);   // outstanding transactions, then reset drops them
      do_reset(2);
      spurious = 1; cycle(); spurious = 0;
      phase(0, 0, 0, 3);
      do_reset(2);
      phase(50, 60, 50, 100);
      drain();
      @(posedge clk);
      #6;
      chk("gnt_q_left", 128'(gnt_q.size()), 128'(0));
      chk("rsp_q_left", 128'(rsp_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/data_bus_arbiter.md
# data_bus_arbiter

Two-requester arbiter for the testbench data-memory port. It shares one OBI-style downstream port (data_req/gnt/rvalid, as consumed by the data memory model) between the core load/store unit (m0) and a secondary bus master (m1, such as the stack-zeroing or revocation engine). It forwards the winning request and keeps an in-order ID FIFO of outstanding transactions. It uses that FIFO to steer each response back to the requester that issued it.

## Interface
- DW, 65: data width including capability tag bit (65 or 33).
- MAX_OUTST, 4: maximum outstanding granted-but-unanswered transactions; power of two, 2..16.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- m0_req / m1_req  in  1  request from requester 0 / 1.
- m0_we, m1_we  in  1  write enable.
- m0_be, m1_be  in  4  byte enables.
- m0_is_cap, m1_is_cap  in  1  capability access.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  DW  write data.
- m0_flag, m1_flag  in  8  sideband flags (bit0 isr, bit2 stkz).
- m0_gnt, m1_gnt  out  1  grant to requester.
- m0_rvalid, m1_rvalid  out  1  response valid.
- m0_rdata, m1_rdata  out  DW  read data.
- m0_err, m1_err  out  1  response error.
- s_req, s_we, s_be, s_is_cap, s_addr, s_wdata, s_flag  out  1/1/4/1/32/DW/8  downstream request.
- s_gnt  in  1  downstream grant.
- s_rvalid, s_rdata, s_err  in  1/DW/1  downstream response.
- outst_cnt  out  $clog2(MAX_OUTST)+1  number of outstanding transactions.
- proto_err  out  1  sticky flag: s_rvalid arrived with no outstanding transaction.

## Operation
- Arbitration states:
  - IDLE: no downstream request is pending.
  - LOCKED(id): the selected requester's request is driven on s_* but has not yet been granted.
- While LOCKED, the selection cannot change, even if the other requester asserts req, so the OBI address phase stays stable.
- LOCKED exits to IDLE on s_gnt. Back-to-back grants are allowed: the same cycle may re-select a requester.
- Selection from IDLE:
  - Only one requester asserts req: that requester wins.
  - Both assert req: the priority rule in Configuration decides.
- s_req = selected req & ~full. All other s_* fields mux from the selected requester and are zero when nothing is selected.
- mX_gnt = s_gnt & s_req & (sel==X). The non-selected requester's gnt is 0.
- ID FIFO:
  - Push sel on s_req & s_gnt.
  - Pop on s_rvalid.
  - full = (outst_cnt == MAX_OUTST). When full, s_req is held low even if a pop occurs in the same cycle.
- Responses return in order. The head ID steers the response: m<head>_rvalid = s_rvalid, and m<head>_rdata/m<head>_err carry s_rdata/s_err. The other requester's rvalid, rdata and err are 0.
- s_rvalid while the FIFO is empty: no pop, no mX_rvalid, and proto_err is set until reset.
- Simultaneous push and pop: outst_cnt is unchanged and the FIFO head advances.

## Timing
- Request path is combinational: mX_req to s_req takes 0 cycles, and s_gnt to mX_gnt takes 0 cycles.
- Response path is combinational: s_rvalid to mX_rvalid takes 0 cycles.
- ID is pushed at the posedge where s_req & s_gnt are both high.
- The earliest matching response can arrive in the following cycle.
- Reset values: all outputs 0; FIFO empty; outst_cnt 0; state IDLE; RR pointer = 1, so m0 is favoured first.
- Reset mid-transaction drops the outstanding IDs. Responses arriving after reset set proto_err.

## Configuration
- DBA_RR_EN defined: round-robin arbitration.
  - A one-bit last-granted pointer updates on each s_gnt handshake.
  - On contention, the requester that is not the last-granted one wins.
- DBA_RR_EN undefined: fixed priority, with m0 always winning contention. The pointer logic is absent.

## Structure
- kudu_dv_pkg gets:
  - typedef dba_id_t, a one-bit requester ID.
  - localparam DBA_NREQ = 2.
  - The arbitration state enum.
- Sub-module dba_id_fifo holds the parameterised MAX_OUTST-deep, one-bit-wide synchronous FIFO with the count, full and empty outputs. It has the same clk/rst_n.

## Test plan
- m0 alone reads 0x8000_0010; s_gnt is delayed 3 cycles; s_rvalid arrives 2 cycles after grant with rdata=0x1234 → m0_gnt high only in the grant cycle, m0_rvalid/m0_rdata=0x1234, m1 outputs stay 0, outst_cnt goes 1→0.
- m0 and m1 request together for 4 back-to-back transfers with s_gnt always high → with DBA_RR_EN the grant order is m0,m1,m0,m1; without it the grant order is m0×4 and m1 is not granted until m0 deasserts req.
- m1 is LOCKED with s_gnt held low for 5 cycles while m0 asserts req → s_addr stays equal to m1_addr throughout and m0_gnt stays 0.
- MAX_OUTST=4 grants with no responses → outst_cnt=4 and s_req stays 0 while a request is pending. One s_rvalid arrives → the next cycle s_req reasserts.
- Interleaved grants in the order m0,m1,m0, then 3 responses with err on the second → responses route m0,m1(err=1),m0 in order.
- s_rvalid injected with an empty FIFO → proto_err=1 and stays 1; no mX_rvalid. Asserting rst_n low clears it.
